dmem_arbiter: RTL and testbench

Two-port arbiter that shares the cache's single data port (AR/R and AW/W/B channels) between the pipeline's load/store unit (port 0) and a secondary master such as the program loader or an IO/DMA engine (port 1). It accepts one request at a time, issues the matching cache strobe, waits for the cache's completion pulse, and returns the result to the granted requester. It sits between the requesters and the cache data interface; the instruction-fetch port (pc, pc_flag, instruction) is not routed through it.

---
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single cache data port (AR/R, AW/W/B) between the
// load/store unit (port 0) and a secondary master (port 1), one transaction at a time.
// Optional build macro DMEM_ARB_RR_EN selects round-robin; otherwise fixed priority (port 0 wins).
// Latency: request -> strobe/ready next cycle; completion at k -> response at k+1.

module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  // port 0: load/store unit
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_bvalid,
  // port 1: secondary master
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_bvalid,
  // cache data interface
  output logic [ADDR_WIDTH-1:0] core_ARADDR,
  output logic                  core_ARVALID,
  input  logic [DATA_WIDTH-1:0] core_RDATA,
  input  logic                  core_RVALID,
  output logic [ADDR_WIDTH-1:0] core_AWADDR,
  output logic                  core_AWVALID,
  output logic [DATA_WIDTH-1:0] core_WDATA,
  input  logic                  core_BVALID,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RD_WAIT = 2'd1,
    S_WR_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_port;
  logic                  r_arvalid;
  logic                  r_awvalid;
  logic [1:0]            r_ready;
  logic [1:0]            r_rvalid;
  logic [1:0]            r_bvalid;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic                  r_busy;
`ifdef DMEM_ARB_RR_EN
  logic                  r_last_grant;
`endif

  logic                  w_any;
  logic                  w_winner;
  logic                  w_sel_write;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  assign w_any = req0_valid | req1_valid;

  // Pick the winning port and mux its request fields (only meaningful when w_any).
  always_comb begin
    w_winner = 1'b0;
`ifdef DMEM_ARB_RR_EN
    // Contended: the port that did not win last time goes first.
    if (req0_valid && req1_valid) w_winner = ~r_last_grant;
    else                          w_winner = ~req0_valid;
`else
    w_winner = ~req0_valid;
`endif
    w_sel_write = w_winner ? req1_write : req0_write;
    w_sel_addr  = w_winner ? req1_addr  : req0_addr;
    w_sel_wdata = w_winner ? req1_wdata : req0_wdata;
  end

  // Transaction FSM; every output is a register written here.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_port       <= 1'b0;
      r_arvalid    <= 1'b0;
      r_awvalid    <= 1'b0;
      r_ready      <= 2'b00;
      r_rvalid     <= 2'b00;
      r_bvalid     <= 2'b00;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
      r_busy       <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      r_last_grant <= 1'b0;
`endif
    end else begin
      // Strobes and handshake pulses last a single cycle.
      r_arvalid <= 1'b0;
      r_awvalid <= 1'b0;
      r_ready   <= 2'b00;
      r_rvalid  <= 2'b00;
      r_bvalid  <= 2'b00;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_addr            <= w_sel_addr;
            r_wdata           <= w_sel_wdata;
            r_port            <= w_winner;
            r_ready[w_winner] <= 1'b1;
            r_busy            <= 1'b1;
`ifdef DMEM_ARB_RR_EN
            r_last_grant      <= w_winner;
`endif
            if (w_sel_write) begin
              r_state   <= S_WR_WAIT;
              r_awvalid <= 1'b1;
            end else begin
              r_state   <= S_RD_WAIT;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_RD_WAIT: begin
          // Write completions are not ours here and are ignored.
          if (core_RVALID) begin
            r_state          <= S_IDLE;
            r_busy           <= 1'b0;
            r_rvalid[r_port] <= 1'b1;
            if (r_port) r_rdata1 <= core_RDATA;
            else        r_rdata0 <= core_RDATA;
          end
        end
        S_WR_WAIT: begin
          if (core_BVALID) begin
            r_state          <= S_IDLE;
            r_busy           <= 1'b0;
            r_bvalid[r_port] <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready   = r_ready[0];
  assign req1_ready   = r_ready[1];
  assign req0_rvalid  = r_rvalid[0];
  assign req1_rvalid  = r_rvalid[1];
  assign req0_bvalid  = r_bvalid[0];
  assign req1_bvalid  = r_bvalid[1];
  assign req0_rdata   = r_rdata0;
  assign req1_rdata   = r_rdata1;
  assign core_ARADDR  = r_addr;
  assign core_AWADDR  = r_addr;
  assign core_WDATA   = r_wdata;
  assign core_ARVALID = r_arvalid;
  assign core_AWVALID = r_awvalid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: reset values, a cycle-by-cycle vector table,
// hand-written multi-cycle sequences and a randomized run against a transaction model.
module tb_dmem_arbiter;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ready, req0_rvalid, req0_bvalid;
  logic        req1_ready, req1_rvalid, req1_bvalid;
  logic [31:0] req0_rdata, req1_rdata;
  logic [31:0] core_ARADDR, core_AWADDR, core_WDATA, core_RDATA;
  logic        core_ARVALID, core_AWVALID, core_RVALID, core_BVALID, busy;

  int n_total = 0;
  int n_bad   = 0;

  always #5 ACLK = ~ACLK;

  dmem_arbiter dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata), .req0_bvalid(req0_bvalid),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata), .req1_bvalid(req1_bvalid),
    .core_ARADDR(core_ARADDR), .core_ARVALID(core_ARVALID), .core_RDATA(core_RDATA), .core_RVALID(core_RVALID),
    .core_AWADDR(core_AWADDR), .core_AWVALID(core_AWVALID), .core_WDATA(core_WDATA), .core_BVALID(core_BVALID),
    .busy(busy)
  );

  // Flag bits: 8 r0, 7 r1, 6 rv0, 5 rv1, 4 bv0, 3 bv1, 2 ar, 1 aw, 0 busy
  wire [8:0] w_flags = {req0_ready, req1_ready, req0_rvalid, req1_rvalid,
                        req0_bvalid, req1_bvalid, core_ARVALID, core_AWVALID, busy};

  typedef struct packed {
    logic        v0, w0; logic [31:0] a0, d0;
    logic        v1, w1; logic [31:0] a1, d1;
    logic        rv, bv; logic [31:0] rdata;
    logic [8:0]  ef;     logic [31:0] erd0;
    logic        chk;    logic [31:0] eaddr, ewdata;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic v0, logic w0, logic [31:0] a0, logic [31:0] d0,
                              logic v1, logic w1, logic [31:0] a1, logic [31:0] d1,
                              logic rv, logic bv, logic [31:0] rdata, logic [8:0] ef,
                              logic [31:0] erd0, logic chk, logic [31:0] eaddr, logic [31:0] ewdata);
    vec_t r;
    r.v0 = v0; r.w0 = w0; r.a0 = a0; r.d0 = d0;
    r.v1 = v1; r.w1 = w1; r.a1 = a1; r.d1 = d1;
    r.rv = rv; r.bv = bv; r.rdata = rdata; r.ef = ef; r.erd0 = erd0;
    r.chk = chk; r.eaddr = eaddr; r.ewdata = ewdata;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_in();
    req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
    core_RVALID = 0; core_BVALID = 0; core_RDATA = 0;
  endtask

  // Randomized-phase requester and model state
  bit          pv [2], pw [2], acc [2];
  logic [31:0] pa [2], pd [2];
  bit          m_act, m_wr, m_port, m_lg, w;
  logic [31:0] m_addr, m_wd, e_rd0, e_rd1;
  logic [8:0]  e_fl;
  int          cdel;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int grants [4];
    int ng, cyc, ns, nr, due, chg_at;
    int strobe_cyc [2];
    int rv_cyc [2];
    logic [31:0] rd_tab [2];

    // ---------------- reset state ----------------
    idle_in();
    ARESETN = 0;
    repeat (2) @(posedge ACLK);
    #1;
    chk("reset_flags", w_flags, 0);
    chk("reset_rdata0", req0_rdata, 0);
    chk("reset_rdata1", req1_rdata, 0);
    chk("reset_araddr", core_ARADDR, 0);
    chk("reset_wdata", core_WDATA, 0);
    ARESETN = 1;
    tick();
    chk("post_reset_flags", w_flags, 0);

    // ---------------- vector table ----------------
    // Row i: inputs driven in cycle i, outputs expected in cycle i+1.
    tbl[0]  = mk(1,0,32'h100,0, 0,0,0,0, 0,0,0,            9'b100000101, 0,            1, 32'h100, 0);
    tbl[1]  = mk(1,0,32'h100,0, 0,0,0,0, 0,0,0,            9'b000000001, 0,            1, 32'h100, 0);
    tbl[2]  = mk(0,0,0,0,       0,0,0,0, 0,0,0,            9'b000000001, 0,            0, 0, 0);
    tbl[3]  = mk(0,0,0,0,       0,0,0,0, 0,0,0,            9'b000000001, 0,            0, 0, 0);
    tbl[4]  = mk(0,0,0,0,       0,0,0,0, 0,0,0,            9'b000000001, 0,            0, 0, 0);
    tbl[5]  = mk(0,0,0,0,       0,0,0,0, 1,0,32'hDEADBEEF, 9'b001000000, 32'hDEADBEEF, 0, 0, 0);
    tbl[6]  = mk(0,0,0,0,       0,0,0,0, 0,0,0,            9'b000000000, 32'hDEADBEEF, 0, 0, 0);
    tbl[7]  = mk(0,0,0,0,       0,0,0,0, 1,1,32'h11111111, 9'b000000000, 32'hDEADBEEF, 0, 0, 0);
    tbl[8]  = mk(0,0,0,0, 1,1,32'h200,32'h12345678, 0,0,0, 9'b010000011, 32'hDEADBEEF, 1, 32'h200, 32'h12345678);
    tbl[9]  = mk(0,0,0,0, 1,1,32'h200,32'h12345678, 0,1,0, 9'b000001000, 32'hDEADBEEF, 0, 0, 0);
    tbl[10] = mk(0,0,0,0,       0,0,0,0, 0,0,0,            9'b000000000, 32'hDEADBEEF, 0, 0, 0);
    tbl[11] = mk(1,0,32'h300,0, 0,0,0,0, 0,0,0,            9'b100000101, 32'hDEADBEEF, 1, 32'h300, 0);
    tbl[12] = mk(1,0,32'h300,0, 0,0,0,0, 0,1,0,            9'b000000001, 32'hDEADBEEF, 0, 0, 0);
    tbl[13] = mk(0,0,0,0,       0,0,0,0, 0,1,0,            9'b000000001, 32'hDEADBEEF, 0, 0, 0);
    tbl[14] = mk(0,0,0,0,       0,0,0,0, 1,0,32'hCAFEF00D, 9'b001000000, 32'hCAFEF00D, 0, 0, 0);
    tbl[15] = mk(0,0,0,0,       0,0,0,0, 0,0,0,            9'b000000000, 32'hCAFEF00D, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      req0_valid = tbl[i].v0; req0_write = tbl[i].w0; req0_addr = tbl[i].a0; req0_wdata = tbl[i].d0;
      req1_valid = tbl[i].v1; req1_write = tbl[i].w1; req1_addr = tbl[i].a1; req1_wdata = tbl[i].d1;
      core_RVALID = tbl[i].rv; core_BVALID = tbl[i].bv; core_RDATA = tbl[i].rdata;
      tick();
      chk($sformatf("vec%0d_flags", i), w_flags, tbl[i].ef);
      chk($sformatf("vec%0d_rdata0", i), req0_rdata, tbl[i].erd0);
      if (tbl[i].chk) begin
        if (tbl[i].ef[2]) chk($sformatf("vec%0d_araddr", i), core_ARADDR, tbl[i].eaddr);
        if (tbl[i].ef[1]) begin
          chk($sformatf("vec%0d_awaddr", i), core_AWADDR, tbl[i].eaddr);
          chk($sformatf("vec%0d_wdata", i), core_WDATA, tbl[i].ewdata);
        end
      end
    end

    // ---------------- reset in RD_WAIT ----------------
    idle_in();
    req0_valid = 1; req0_addr = 32'h400;
    tick();                       // strobe cycle
    tick();                       // waiting for completion
    req0_valid = 0;
    ARESETN = 0;
    #1;
    chk("rst_mid_flags", w_flags, 0);
    chk("rst_mid_rdata0", req0_rdata, 0);
    chk("rst_mid_araddr", core_ARADDR, 0);
    tick();
    ARESETN = 1;
    core_RVALID = 1; core_RDATA = 32'h55;
    tick();
    core_RVALID = 0;
    chk("rst_after_flags", w_flags, 0);
    chk("rst_after_rdata0", req0_rdata, 0);
    tick();
    chk("rst_after2_flags", w_flags, 0);

    // ---------------- both ports storing continuously ----------------
    idle_in();
    req0_valid = 1; req0_write = 1; req0_addr = 32'h10; req0_wdata = 32'hA;
    req1_valid = 1; req1_write = 1; req1_addr = 32'h20; req1_wdata = 32'hB;
    for (int k = 0; k < 4; k++) grants[k] = 2;
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      tick();
      core_BVALID = core_AWVALID;
      if (req0_ready || req1_ready) begin
        grants[ng] = req1_ready ? 1 : 0;
        chk("contend_awaddr", core_AWADDR, req1_ready ? 32'h20 : 32'h10);
        ng++;
      end
    end
    chk("contend_grant_count", ng, 4);
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
      chk($sformatf("contend_grant%0d", k), grants[k], (k % 2 == 0) ? 1 : 0);
`else
      chk($sformatf("contend_grant%0d", k), grants[k], 0);
`endif
    end
    tick();
    idle_in();
    tick();
    chk("contend_drain_busy", busy, 0);

    // ---------------- back-to-back loads, completion 2 cycles after strobe ----------------
    idle_in();
    rd_tab[0] = 32'hA0A0A0A1; rd_tab[1] = 32'hB0B0B0B2;
    strobe_cyc[0] = 0; strobe_cyc[1] = 0; rv_cyc[0] = -100; rv_cyc[1] = -100;
    req0_valid = 1; req0_addr = 32'h500;
    cyc = 0; ns = 0; nr = 0; due = -1; chg_at = -1;
    for (int c = 0; c < 40 && nr < 2; c++) begin
      tick();
      cyc++;
      if (cyc == chg_at) begin
        if (ns == 1) req0_addr = 32'h504;
        else         req0_valid = 0;
      end
      if (req0_rvalid) begin
        rv_cyc[nr] = cyc;
        chk("b2b_rdata", req0_rdata, rd_tab[nr]);
        nr++;
      end
      if (core_ARVALID) begin
        if (ns < 2) strobe_cyc[ns] = cyc;
        chk("b2b_araddr", core_ARADDR, (ns == 0) ? 32'h500 : 32'h504);
        due = cyc + 2;
        ns++;
      end
      if (req0_ready) chg_at = cyc + 1;
      core_RVALID = (cyc == due);
      core_RDATA  = (cyc == due && ns > 0 && ns <= 2) ? rd_tab[ns-1] : 32'h0;
    end
    chk("b2b_resp_count", nr, 2);
    chk("b2b_gap", strobe_cyc[1], rv_cyc[0] + 1);
    idle_in();

    // ---------------- randomized run against transaction model ----------------
    ARESETN = 0;
    tick();
    ARESETN = 1;
    for (int p = 0; p < 2; p++) begin pv[p] = 0; pw[p] = 0; pa[p] = 0; pd[p] = 0; acc[p] = 0; end
    m_act = 0; m_wr = 0; m_port = 0; m_lg = 0; m_addr = 0; m_wd = 0;
    e_rd0 = 0; e_rd1 = 0; e_fl = 0; cdel = -1;

    for (int t = 0; t < 1500; t++) begin
      tick();
      chk("rnd_flags", w_flags, e_fl);
      chk("rnd_rdata0", req0_rdata, e_rd0);
      chk("rnd_rdata1", req1_rdata, e_rd1);
      if (m_act) begin
        if (m_wr) begin
          chk("rnd_awaddr", core_AWADDR, m_addr);
          chk("rnd_wdata", core_WDATA, m_wd);
        end else begin
          chk("rnd_araddr", core_ARADDR, m_addr);
        end
      end

      // requesters: hold until accepted, drop the cycle after acceptance
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin pv[p] = 0; acc[p] = 0; end
        if (!pv[p] && ($urandom % 3 == 0)) begin
          pv[p] = 1; pw[p] = $urandom % 2;
          pa[p] = $urandom; pd[p] = $urandom;
        end
        if (e_fl[8-p]) acc[p] = 1;
      end
      req0_valid = pv[0]; req0_write = pw[0]; req0_addr = pa[0]; req0_wdata = pd[0];
      req1_valid = pv[1]; req1_write = pw[1]; req1_addr = pa[1]; req1_wdata = pd[1];

      // cache: completion 0..3 cycles after the strobe, plus stray pulses
      core_RVALID = 0; core_BVALID = 0; core_RDATA = $urandom;
      if (m_act) begin
        if (e_fl[2] || e_fl[1]) cdel = $urandom_range(0, 3);
        if (cdel == 0) begin
          if (m_wr) core_BVALID = 1; else core_RVALID = 1;
        end
        cdel--;
        if ($urandom % 5 == 0) begin
          if (m_wr) core_RVALID = 1; else core_BVALID = 1;
        end
      end else begin
        core_RVALID = ($urandom % 4 == 0);
        core_BVALID = ($urandom % 4 == 0);
      end

      // model: what the outputs must look like after this edge
      e_fl = 0;
      if (!m_act) begin
        if (pv[0] || pv[1]) begin
`ifdef DMEM_ARB_RR_EN
          if (pv[0] && pv[1]) w = !m_lg;
          else                w = pv[1];
`else
          w = pv[0] ? 1'b0 : 1'b1;
`endif
          m_act = 1; m_port = w; m_wr = pw[w]; m_addr = pa[w]; m_wd = pd[w]; m_lg = w;
          e_fl[8-w] = 1;
          if (m_wr) e_fl[1] = 1; else e_fl[2] = 1;
        end
      end else if (m_wr ? core_BVALID : core_RVALID) begin
        m_act = 0;
        if (m_wr) e_fl[4-m_port] = 1;
        else begin
          e_fl[6-m_port] = 1;
          if (m_port) e_rd1 = core_RDATA; else e_rd0 = core_RDATA;
        end
      end
      e_fl[0] = m_act;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
